mult_cmd_sequencer: RTL and testbench

- Upstream command stage for the three-cycle 8x8 multiplier.
- Accepts tagged multiply commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one command at a time to the multiplier's A/B/start/done handshake, then returns the 16-bit product with its tag over a valid/ready response interface.

---
 rtl/mult_seq_pkg.sv | 18 +
 rtl/mult_seq_fifo.sv | 77 +++++++
 rtl/mult_cmd_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mult_cmd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// rtl/mult_seq_pkg.sv - shared types and constants for the multiply command sequencer
//
// Holds the sequencer state encoding, the operand/result widths and the
// result value reported when a command times out.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int OPW  = 8;
  localparam int RESW = 16;

  localparam logic [RESW-1:0] TIMEOUT_RESULT = 16'hFFFF;

endpackage

// File: rtl/mult_seq_fifo.sv
// rtl/mult_seq_fifo.sv - synchronous command FIFO holding {tag, a, b}
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   push, wdata     write request and data; ignored while full
//   pop, rdata      read request; rdata shows the head entry whenever not empty
//   full, empty     flags derived from the registered occupancy count
module mult_seq_fifo
  import mult_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = wdata;
      // DEPTH is a power of two, so the pointer wraps on its own.
      wptr_d = wptr_q + 1'b1;
    end
    if (pop_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + 1'b1;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mult_cmd_sequencer.sv
// rtl/mult_cmd_sequencer.sv - buffers tagged multiply commands and drives the 8x8 multiplier
//
// Optional build macro: MULT_SEQ_TIMEOUT_EN adds an ISSUE watchdog.
// Ports:
//   clk, reset                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_a/b/tag     command input, cmd_ready = FIFO not full
//   mult_a/mult_b/mult_start            operands and start level to the multiplier
//   mult_done/mult_result               one-cycle completion pulse and product
//   rsp_valid/rsp_ready/rsp_result/tag  response output, held until consumed
//   busy                                FIFO non-empty or sequencer not idle
//   err_timeout                         sticky watchdog flag
module mult_cmd_sequencer
  import mult_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_a,
  input  logic [OPW-1:0]   cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [OPW-1:0]   mult_a,
  output logic [OPW-1:0]   mult_b,
  output logic             mult_start,
  input  logic             mult_done,
  input  logic [RESW-1:0]  mult_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RESW-1:0]  rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             err_timeout
);

  localparam int FW = TAG_W + 2 * OPW;

  logic [FW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;

  state_e           state_q, state_d;
  logic [OPW-1:0]   mult_a_q, mult_a_d;
  logic [OPW-1:0]   mult_b_q, mult_b_d;
  logic             mult_start_q, mult_start_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [RESW-1:0]  rsp_result_q, rsp_result_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             err_timeout_q, err_timeout_d;

`ifdef MULT_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
`else
  logic             unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  assign fifo_push = cmd_valid && !fifo_full;

  mult_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({cmd_tag, cmd_a, cmd_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    mult_start_d  = mult_start_q;
    tag_d         = tag_q;
    rsp_result_d  = rsp_result_q;
    rsp_valid_d   = rsp_valid_q;
    err_timeout_d = err_timeout_q;
    fifo_pop      = 1'b0;
`ifdef MULT_SEQ_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          {tag_d, mult_a_d, mult_b_d} = fifo_rdata;
          mult_start_d = 1'b1;
          state_d      = ISSUE;
`ifdef MULT_SEQ_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      ISSUE: begin
        // A real done wins over a watchdog expiring on the same edge.
        if (mult_done) begin
          rsp_result_d = mult_result;
          mult_start_d = 1'b0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
`ifdef MULT_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          rsp_result_d  = TIMEOUT_RESULT;
          mult_start_d  = 1'b0;
          rsp_valid_d   = 1'b1;
          err_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      mult_start_q  <= 1'b0;
      tag_q         <= '0;
      rsp_result_q  <= '0;
      rsp_valid_q   <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef MULT_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      mult_start_q  <= mult_start_d;
      tag_q         <= tag_d;
      rsp_result_q  <= rsp_result_d;
      rsp_valid_q   <= rsp_valid_d;
      err_timeout_q <= err_timeout_d;
`ifdef MULT_SEQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign cmd_ready   = !fifo_full;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign mult_start  = mult_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_tag     = tag_q;
  assign busy        = !fifo_empty || (state_q != IDLE);
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mult_cmd_sequencer.sv
// tb/tb_mult_cmd_sequencer.sv - scoreboard bench for the multiply command sequencer
module tb_mult_cmd_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [7:0]       cmd_a = '0;
  logic [7:0]       cmd_b = '0;
  logic [TAG_W-1:0] cmd_tag = '0;
  logic [7:0]       mult_a, mult_b;
  logic             mult_start;
  logic             mult_done;
  logic [15:0]      mult_result;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic             err_timeout;

  logic             model_done = 1'b0;
  logic [15:0]      model_result = '0;
  logic             inj_done = 1'b0;
  logic [15:0]      inj_result = '0;
  bit               mult_en = 1'b1;
  int               mcnt = 0;

  typedef struct {
    logic [15:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  assign mult_done   = model_done | inj_done;
  assign mult_result = inj_done ? inj_result : model_result;

  mult_cmd_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_tag     (cmd_tag),
    .mult_a      (mult_a),
    .mult_b      (mult_b),
    .mult_start  (mult_start),
    .mult_done   (mult_done),
    .mult_result (mult_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_tag     (rsp_tag),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Three-cycle multiplier: done is presented so that it is sampled on the
  // fifth edge after the one that raised mult_start.
  always begin
    @(posedge clk);
    #1;
    if (reset || !mult_en) begin
      model_done = 1'b0;
      mcnt = 0;
    end else if (model_done) begin
      model_done = 1'b0;
      mcnt = 0;
    end else if (mult_start) begin
      mcnt++;
      if (mcnt == 5) begin
        model_done   = 1'b1;
        model_result = mult_a * mult_b;
      end
    end else begin
      mcnt = 0;
    end
  end

  // Response monitor: a handshake completes on the next edge.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {16'd0, rsp_result}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_result", {16'd0, rsp_result}, {16'd0, e.res});
        check("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
      end
    end
  end

  // Call #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [TAG_W-1:0] tag,
                      input logic [15:0] exp_res, output bit stalled, output int acc_cyc);
    bit accepted;
    exp_t e;
    accepted = 1'b0;
    stalled  = 1'b0;
    acc_cyc  = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_tag = tag;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
      end else begin
        stalled = 1'b1;
      end
    end
    cmd_valid = 1'b0;
    if (!accepted) begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
    end else begin
      acc_cyc = cyc;
      e.res = exp_res;
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !busy && !rsp_valid) done = 1'b1;
    end
    check("drain", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_rsp_valid(output int rise_cyc);
    bit seen;
    seen = 1'b0;
    rise_cyc = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        rise_cyc = cyc;
      end
    end
    check("rsp_valid_seen", {31'd0, seen}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit stalled;
    int acc, rise;
    int first_stall;

    // Reset values
    #12;
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_mult_start", {31'd0, mult_start}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_err_timeout", {31'd0, err_timeout}, 32'd0);
    check("reset_rsp_result", {16'd0, rsp_result}, 32'd0);
    check("reset_mult_ab", {16'd0, mult_a, mult_b}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single command and its latency
    send(8'd12, 8'd10, 4'd3, 16'd120, stalled, acc);
    check("start_not_yet", {31'd0, mult_start}, 32'd0);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("start_after_n1", {31'd0, mult_start}, 32'd1);
    check("mult_ab_loaded", {16'd0, mult_a, mult_b}, {16'd0, 8'd12, 8'd10});
    wait_rsp_valid(rise);
    check("rsp_latency", rise - acc, 32'd6);
    @(posedge clk);
    #1;
    drain();

    // Corner operands back to back
    send(8'd255, 8'd255, 4'd5, 16'hFE01, stalled, acc);
    send(8'd0, 8'd200, 4'd6, 16'd0, stalled, acc);
    send(8'd1, 8'd255, 4'd7, 16'd255, stalled, acc);
    drain();

    // Burst of six: the sixth is the first to see a full FIFO
    first_stall = -1;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] a, b;
      a = 8'(17 * i + 3);
      b = 8'(29 * i + 11);
      send(a, b, 4'(8 + i), 16'(a * b), stalled, acc);
      if (stalled && first_stall < 0) first_stall = i;
    end
    check("burst_first_stall", first_stall, 32'd5);
    drain();

    // Response back-pressure
    rsp_ready = 1'b0;
    send(8'd7, 8'd9, 4'd2, 16'd63, stalled, acc);
    wait_rsp_valid(rise);
    @(posedge clk);
    #1;
    send(8'd3, 8'd5, 4'd4, 16'd15, stalled, acc);
    check("accept_while_resp", {31'd0, stalled}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_rsp", {13'd0, rsp_valid, mult_start, rsp_tag, rsp_result},
            {13'd0, 1'b1, 1'b0, 4'd2, 16'd63});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_gap_start", {30'd0, mult_start, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("next_issue", {15'd0, mult_start, mult_a, mult_b}, {15'd0, 1'b1, 8'd3, 8'd5});
    drain();

    // Reset during ISSUE, then a stale done pulse
    send(8'd20, 8'd20, 4'd1, 16'd400, stalled, acc);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {26'd0, mult_start, rsp_valid, busy, cmd_ready, err_timeout, 1'b0},
          {26'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mult_en = 1'b0;
    inj_result = 16'h1234;
    inj_done = 1'b1;
    @(posedge clk);
    #1;
    inj_done = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("stale_done_ignored", {29'd0, rsp_valid, busy, mult_start}, 32'd0);

`ifdef MULT_SEQ_TIMEOUT_EN
    // Watchdog: no done at all
    send(8'd9, 8'd9, 4'd9, 16'hFFFF, stalled, acc);
    wait_rsp_valid(rise);
    check("timeout_latency", rise - acc, 32'd16);
    check("err_timeout_set", {31'd0, err_timeout}, 32'd1);
    @(posedge clk);
    #1;
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("err_timeout_sticky", {31'd0, err_timeout}, 32'd1);
    reset = 1'b1;
    #1;
    check("err_timeout_cleared", {31'd0, err_timeout}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
`else
    // Without the watchdog ISSUE waits for done indefinitely
    send(8'd9, 8'd9, 4'd9, 16'hBEEF, stalled, acc);
    repeat (30) @(posedge clk);
    #1;
    check("issue_waits", {29'd0, rsp_valid, mult_start, err_timeout}, {29'd0, 3'b010});
    inj_result = 16'hBEEF;
    inj_done = 1'b1;
    @(posedge clk);
    #1;
    inj_done = 1'b0;
    drain();
    check("err_timeout_tied", {31'd0, err_timeout}, 32'd0);
`endif

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
